// File: rtl/msg_arb_pkg.sv
// Shared types and constants for the message beat arbiter.
package msg_arb_pkg;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_e;

    // Completed-message counter width; the counter wraps naturally.
    localparam int unsigned MsgCountW = 16;

    // Width of a requester index; never narrower than one bit.
    function automatic int unsigned id_width(int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/msg_rr_pick.sv
// Round-robin picker: first set req bit at or above ptr, wrapping around.
module msg_rr_pick import msg_arb_pkg::*; #(
    parameter int unsigned N   = 4,
    parameter int unsigned IdW = id_width(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IdW-1:0] ptr_i,
    output logic           found_o,
    output logic [IdW-1:0] idx_o
);

    int unsigned j;

    // Scan offsets from far to near so the nearest hit to ptr wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % N;
            if (req_i[j]) begin
                found_o = 1'b1;
                idx_o   = IdW'(j);
            end
        end
    end

endmodule

// File: rtl/msg_beat_arbiter.sv
// Round-robin arbiter sharing one EN/RDY beat channel among N producers.
// The grant is held for a whole message; a beat watchdog forces release.
module msg_beat_arbiter import msg_arb_pkg::*; #(
    parameter int unsigned N        = 4,
    parameter int unsigned width    = 32,
    parameter int unsigned maxBeats = 256,
    localparam int unsigned idW     = id_width(N)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         EN_in,
    input  logic [N*width-1:0]   beat_in,
    input  logic [N-1:0]         last_in,
    output logic [N-1:0]         RDY_in,
    output logic                 EN_out,
    output logic [width-1:0]     beat_out,
    output logic                 last_out,
    input  logic                 RDY_out,
    output logic                 grant_valid,
    output logic [idW-1:0]       grant_id,
    output logic                 err_overrun,
    output logic [MsgCountW-1:0] msg_count
);

    localparam int unsigned CntW = $clog2(maxBeats + 1);

    arb_state_e           state_q, state_d;
    logic [idW-1:0]       ptr_q, ptr_d;
    logic [idW-1:0]       grant_id_q, grant_id_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [MsgCountW-1:0] msg_count_q, msg_count_d;
    logic                 err_overrun_q, err_overrun_d;

    logic           pick_found;
    logic [idW-1:0] pick_idx;
    logic [idW-1:0] next_ptr;
    logic           xfer;

    msg_rr_pick #(
        .N   (N),
        .IdW (idW)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign xfer     = (state_q == LOCKED) && EN_in[grant_id_q] && RDY_out;
    assign next_ptr = (grant_id_q == idW'(N - 1)) ? '0 : grant_id_q + 1'b1;

    // Channel mux: only the owner sees RDY, only its beat reaches the consumer.
    always_comb begin
        RDY_in   = '0;
        EN_out   = xfer;
        beat_out = '0;
        last_out = 1'b0;
        if (state_q == LOCKED) begin
            RDY_in[grant_id_q] = RDY_out;
        end
        if (xfer) begin
            beat_out = beat_in[grant_id_q*width +: width];
            last_out = last_in[grant_id_q];
        end
    end

    // Next state: arbitrate in IDLE, count beats and release in LOCKED.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_id_d    = grant_id_q;
        cnt_d         = cnt_q;
        msg_count_d   = msg_count_q;
        err_overrun_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_id_d = pick_idx;
                    cnt_d      = '0;
                    state_d    = LOCKED;
                end
            end
            LOCKED: begin
                if (xfer) begin
                    if (last_in[grant_id_q]) begin
                        msg_count_d = msg_count_q + 1'b1;
                        ptr_d       = next_ptr;
                        cnt_d       = '0;
                        state_d     = IDLE;
                    end else if (cnt_q == CntW'(maxBeats - 1)) begin
                        // This was the maxBeats-th beat without last: force release.
                        err_overrun_d = 1'b1;
                        ptr_d         = next_ptr;
                        cnt_d         = '0;
                        state_d       = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            grant_id_q    <= '0;
            cnt_q         <= '0;
            msg_count_q   <= '0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_id_q    <= grant_id_d;
            cnt_q         <= cnt_d;
            msg_count_q   <= msg_count_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign grant_valid = (state_q == LOCKED);
    assign grant_id    = grant_id_q;
    assign err_overrun = err_overrun_q;
    assign msg_count   = msg_count_q;

endmodule

// File: tb/tb_msg_beat_arbiter.sv
// Self-checking bench for msg_beat_arbiter: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_msg_beat_arbiter;

    localparam int unsigned N    = 4;
    localparam int unsigned W    = 32;
    localparam int unsigned MAXB = 8;

    logic           CLK     = 1'b0;
    logic           RST_N   = 1'b0;
    logic [N-1:0]   req     = '0;
    logic [N-1:0]   EN_in   = '0;
    logic [N*W-1:0] beat_in = '0;
    logic [N-1:0]   last_in = '0;
    logic           RDY_out = 1'b0;
    logic [N-1:0]   RDY_in;
    logic           EN_out;
    logic [W-1:0]   beat_out;
    logic           last_out;
    logic           grant_valid;
    logic [1:0]     grant_id;
    logic           err_overrun;
    logic [15:0]    msg_count;

    int errors = 0;
    int checks = 0;

    msg_beat_arbiter #(
        .N        (N),
        .width    (W),
        .maxBeats (MAXB)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .req         (req),
        .EN_in       (EN_in),
        .beat_in     (beat_in),
        .last_in     (last_in),
        .RDY_in      (RDY_in),
        .EN_out      (EN_out),
        .beat_out    (beat_out),
        .last_out    (last_out),
        .RDY_out     (RDY_out),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .err_overrun (err_overrun),
        .msg_count   (msg_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_lanes();
        EN_in   = '0;
        last_in = '0;
    endtask

    task automatic drive(input int lane, input logic [31:0] d, input logic l);
        EN_in                  = '0;
        last_in                = '0;
        EN_in[lane]            = 1'b1;
        last_in[lane]          = l;
        beat_in[lane*W +: W]   = d;
    endtask

    // Behavioural model: who owns the channel, where the scan starts, how many
    // beats the owner has sent, and how many messages have completed.
    bit           m_init = 0;
    bit           m_busy;
    bit           m_err;
    int           m_owner;
    int           m_ptr;
    int           m_beats;
    int           m_msgs;

    always @(negedge CLK) begin
        logic [N-1:0] exp_rdy;
        bit           x_en;
        int           j;
        x_en    = m_busy && EN_in[m_owner] && RDY_out;
        exp_rdy = '0;
        if (m_busy) exp_rdy[m_owner] = RDY_out;
        if (m_init) begin
            chk("m_grant_valid", grant_valid, m_busy);
            chk("m_grant_id", grant_id, m_owner);
            chk("m_rdy_in", RDY_in, exp_rdy);
            chk("m_en_out", EN_out, x_en);
            chk("m_beat_out", beat_out, x_en ? beat_in[m_owner*W +: W] : 32'd0);
            chk("m_last_out", last_out, x_en ? last_in[m_owner] : 1'b0);
            chk("m_err_overrun", err_overrun, m_err);
            chk("m_msg_count", msg_count, m_msgs % 65536);
        end
        // Inputs are stable here until the next rising edge, so advance now.
        if (!RST_N) begin
            m_busy  = 0;
            m_err   = 0;
            m_owner = 0;
            m_ptr   = 0;
            m_beats = 0;
            m_msgs  = 0;
            m_init  = 1;
        end else if (m_init) begin
            m_err = 0;
            if (!m_busy) begin
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (!m_busy && req[j]) begin
                        m_busy  = 1;
                        m_owner = j;
                        m_beats = 0;
                    end
                end
            end else if (x_en) begin
                m_beats++;
                if (last_in[m_owner]) begin
                    m_msgs++;
                    m_busy = 0;
                    m_ptr  = (m_owner + 1) % N;
                end else if (m_beats == MAXB) begin
                    m_err  = 1;
                    m_busy = 0;
                    m_ptr  = (m_owner + 1) % N;
                end
            end
        end
    end

    initial begin
        logic [1:0]  rr_order [5];
        logic        rdy_seq  [4];
        logic [3:0]  exp_rdy_in;
        int          b;
        rr_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rdy_seq  = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Reset state.
        RST_N   = 1'b0;
        RDY_out = 1'b1;
        repeat (2) step();
        RST_N = 1'b1;
        #1;
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_rdy_in", RDY_in, 0);
        chk("rst_en_out", EN_out, 0);
        chk("rst_msg_count", msg_count, 0);
        chk("rst_err", err_overrun, 0);
        chk("rst_grant_id", grant_id, 0);

        // Single requester, 3-beat message on lane 1.
        req = 4'b0010;
        #1;
        chk("t1_no_grant_yet", grant_valid, 0);
        step();
        req = 4'b0000;
        chk("t1_grant_valid", grant_valid, 1);
        chk("t1_grant_id", grant_id, 1);
        drive(1, 32'hA, 1'b0);
        #1;
        chk("t1_en_a", EN_out, 1);
        chk("t1_beat_a", beat_out, 32'hA);
        chk("t1_last_a", last_out, 0);
        step();
        drive(1, 32'hB, 1'b0);
        #1;
        chk("t1_beat_b", beat_out, 32'hB);
        chk("t1_last_b", last_out, 0);
        step();
        drive(1, 32'hC, 1'b1);
        #1;
        chk("t1_beat_c", beat_out, 32'hC);
        chk("t1_last_c", last_out, 1);
        step();
        idle_lanes();
        #1;
        chk("t1_msg_count", msg_count, 1);
        chk("t1_rdy_in_after", RDY_in, 0);
        chk("t1_released", grant_valid, 0);

        // Round-robin from a clean pointer, all four requesting.
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        req   = 4'b1111;
        for (int m = 0; m < 5; m++) begin
            step();
            chk("rr_grant_id", grant_id, rr_order[m]);
            chk("rr_grant_valid", grant_valid, 1);
            drive(int'(rr_order[m]), 32'h100 + m, 1'b1);
            #1;
            chk("rr_beat", beat_out, 32'h100 + m);
            step();
            idle_lanes();
            if (m == 4) req = 4'b0000;
            #1;
            chk("rr_bubble", grant_valid, 0);
        end
        chk("rr_msg_count", msg_count, 5);

        // Stall: lane 2, consumer ready pattern 1,0,0,1 over a 2-beat message.
        req = 4'b0100;
        step();
        req = 4'b0000;
        chk("st_grant_id", grant_id, 2);
        b = 0;
        for (int c = 0; c < 4; c++) begin
            RDY_out = rdy_seq[c];
            if (rdy_seq[c]) begin
                drive(2, 32'h20 + b, b == 1);
                b++;
            end else begin
                idle_lanes();
            end
            exp_rdy_in = '0;
            exp_rdy_in[2] = rdy_seq[c];
            #1;
            chk("st_rdy_in", RDY_in, exp_rdy_in);
            chk("st_en_out", EN_out, rdy_seq[c]);
            if (rdy_seq[c]) chk("st_beat", beat_out, 32'h20 + b - 1);
            step();
        end
        idle_lanes();
        RDY_out = 1'b1;
        #1;
        chk("st_msg_count", msg_count, 6);
        chk("st_released", grant_valid, 0);

        // Watchdog: lane 3 sends 8 beats without last, lane 0 waiting.
        req = 4'b1001;
        step();
        chk("wd_grant_id", grant_id, 3);
        for (int k = 0; k < 8; k++) begin
            drive(3, 32'h300 + k, 1'b0);
            #1;
            chk("wd_en_out", EN_out, 1);
            chk("wd_no_err_yet", err_overrun, 0);
            step();
        end
        idle_lanes();
        #1;
        chk("wd_err_pulse", err_overrun, 1);
        chk("wd_released", grant_valid, 0);
        chk("wd_msg_count", msg_count, 6);
        step();
        req = 4'b0000;
        chk("wd_err_cleared", err_overrun, 0);
        chk("wd_next_grant_valid", grant_valid, 1);
        chk("wd_next_grant_id", grant_id, 0);
        drive(0, 32'h55, 1'b1);
        step();
        idle_lanes();
        #1;
        chk("wd_after_msg_count", msg_count, 7);

        // Reset in the middle of a 4-beat message from lane 0.
        req = 4'b0001;
        step();
        req = 4'b0000;
        chk("rm_grant_id", grant_id, 0);
        drive(0, 32'h60, 1'b0);
        step();
        drive(0, 32'h61, 1'b0);
        step();
        idle_lanes();
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        #1;
        chk("rm_grant_valid", grant_valid, 0);
        chk("rm_rdy_in", RDY_in, 0);
        chk("rm_msg_count", msg_count, 0);
        // A pointer back at 0 picks lane 0 over lane 3.
        req = 4'b1001;
        step();
        req = 4'b0000;
        chk("rm_regrant_valid", grant_valid, 1);
        chk("rm_regrant_id", grant_id, 0);
        drive(0, 32'h70, 1'b1);
        step();
        idle_lanes();
        #1;
        chk("rm_msg_count_after", msg_count, 1);

        // Rogue EN on lane 3 while lane 1 owns the channel.
        req = 4'b0010;
        step();
        req = 4'b0000;
        chk("rg_grant_id", grant_id, 1);
        for (int c = 0; c < 2; c++) begin
            drive(1, 32'h11 + c, c == 1);
            EN_in[3]          = 1'b1;
            beat_in[3*W +: W] = 32'hDEAD;
            #1;
            chk("rg_beat", beat_out, 32'h11 + c);
            chk("rg_rdy3", RDY_in[3], 0);
            step();
        end
        idle_lanes();
        EN_in[3] = 1'b1;
        #1;
        chk("rg_idle_en_out", EN_out, 0);
        chk("rg_idle_beat", beat_out, 0);
        chk("rg_msg_count", msg_count, 2);
        step();
        chk("rg_no_grant", grant_valid, 0);
        idle_lanes();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
